// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES arithmetic package.
//   * byte_t                     : one AES state byte
//   * AES_POLY, SBOX_AFFINE_C    : field polynomial and S-box affine constant
//   * GF16_POLY, GF16_LAMBDA     : GF(2^4) = GF(2)[x]/(x^4+x+1) and the
//                                  quadratic X^2 + X + lambda that extends it
//                                  to GF((2^4)^2)
//   * ISO_MAP, INV_AFFINE_MAP    : 8x8 bit matrices, stored column-wise
//                                  (column j in bits [8j+7:8j])
//   * gf16_mul / gf16_sq / gf16_mul_lambda, mat_mul : datapath helpers
// Composite element layout: bits [7:4] = high coefficient h, bits [3:0] = low
// coefficient l, value = h*X + l.
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [8:0] AES_POLY      = 9'h11B;
    localparam byte_t      SBOX_AFFINE_C = 8'h63;
    localparam logic [4:0] GF16_POLY     = 5'b10011;
    // Trace of 4'hC is 1, so X^2 + X + lambda is irreducible over GF(2^4).
    localparam logic [3:0] GF16_LAMBDA   = 4'hC;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'({3'b000, a}) << i);
        for (int k = 6; k >= 4; k--)
            if (p[k]) p = p ^ (7'(GF16_POLY) << (k - 4));
        return p[3:0];
    endfunction

    // Squaring is linear over GF(2): x^4 = x+1, x^6 = x^3+x^2.
    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul_lambda(input logic [3:0] a);
        return gf16_mul(a, GF16_LAMBDA);
    endfunction

    // Constant 8x8 bit-matrix times vector; folds to an XOR tree.
    function automatic byte_t mat_mul(input logic [63:0] cols, input byte_t v);
        byte_t r;
        r = '0;
        for (int j = 0; j < 8; j++)
            if (v[j]) r = r ^ cols[8*j +: 8];
        return r;
    endfunction

    // ---- Elaboration-time helpers used only to derive the matrices ----------

    // Multiply in GF((2^4)^2) with X^2 = X + lambda.
    function automatic byte_t gf256c_mul(input byte_t a, input byte_t b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul_lambda(hh) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    // Linear part of the S-box affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4.
    function automatic byte_t affine_lin(input byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    // A composite-field root r of the AES polynomial; x^i maps to r^i.
    function automatic byte_t find_root();
        byte_t root, p, acc, cand;
        logic  found;
        root  = 8'h00;
        found = 1'b0;
        for (int c = 2; c < 256 && !found; c++) begin
            cand = 8'(c);
            acc  = 8'h00;
            p    = 8'h01;
            for (int k = 0; k < 9; k++) begin
                if (AES_POLY[k]) acc = acc ^ p;
                p = gf256c_mul(p, cand);
            end
            if (acc == 8'h00) begin
                root  = cand;
                found = 1'b1;
            end
        end
        return root;
    endfunction

    function automatic logic [63:0] derive_iso(input byte_t root);
        logic [63:0] cols;
        byte_t       p;
        cols = '0;
        p    = 8'h01;
        for (int i = 0; i < 8; i++) begin
            cols[8*i +: 8] = p;
            p = gf256c_mul(p, root);
        end
        return cols;
    endfunction

    // Column j is affine_lin(preimage of composite basis vector j).
    function automatic logic [63:0] derive_inv_affine(input logic [63:0] iso);
        logic [63:0] cols;
        cols = '0;
        for (int j = 0; j < 8; j++)
            for (int a = 0; a < 256; a++)
                if (mat_mul(iso, 8'(a)) == (8'h01 << j))
                    cols[8*j +: 8] = affine_lin(8'(a));
        return cols;
    endfunction

    // Matrices are derived from the field definitions so they cannot drift
    // out of step with AES_POLY / GF16_POLY / GF16_LAMBDA.
    localparam logic [63:0] ISO_MAP        = derive_iso(find_root());
    localparam logic [63:0] INV_AFFINE_MAP = derive_inv_affine(ISO_MAP);

endpackage

// File: rtl/gf16_inv.sv
// -----------------------------------------------------------------------------
// gf16_inv
// Combinational multiplicative inverse in GF(2^4) mod x^4+x+1; 0 maps to 0.
// Ports:
//   a     in  4  operand
//   a_inv out 4  a^-1 (a^14 = a^2 * a^4 * a^8)
// -----------------------------------------------------------------------------
module gf16_inv
    import aes_pkg::*;
(
    input  logic [3:0] a,
    output logic [3:0] a_inv
);

    logic [3:0] a2, a4, a8;

    assign a2    = gf16_sq(a);
    assign a4    = gf16_sq(a2);
    assign a8    = gf16_sq(a4);
    assign a_inv = gf16_mul(gf16_mul(a2, a4), a8);

endmodule

// File: rtl/sub_bytes.sv
// -----------------------------------------------------------------------------
// sub_bytes
// AES forward S-box for one byte, built in GF((2^4)^2), registered output.
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous active-high reset, clears all registers to 0
//   state  in  8  byte to substitute
//   Sstate out 8  S(state), latency 1 (2 with SBOX_PIPE_EN)
// Build option:
//   SBOX_PIPE_EN : adds a register after the GF(2^4) inversion stage.
// -----------------------------------------------------------------------------
module sub_bytes
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] state,
    output logic [7:0] Sstate
);

    byte_t      iso;
    logic [3:0] ah, al, norm, norm_inv;
    logic [3:0] ah_s, ahal_s, ninv_s;
    byte_t      inv_byte, sbox_comb, sstate_next, sstate_reg;

    // Into the composite field.
    assign iso = mat_mul(ISO_MAP, state);
    assign ah  = iso[7:4];
    assign al  = iso[3:0];

    // Norm of (ah*X + al): ah^2*lambda + ah*al + al^2.
    assign norm = gf16_mul_lambda(gf16_sq(ah)) ^ gf16_mul(ah, al) ^ gf16_sq(al);

    gf16_inv u_norm_inv (
        .a     (norm),
        .a_inv (norm_inv)
    );

`ifdef SBOX_PIPE_EN
    logic [3:0] ah_reg, ahal_reg, ninv_reg;
    logic       valid_reg;

    // valid_reg keeps the cleared stage from emitting S(0)=0x63 right after
    // reset; the first post-reset output is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ah_reg    <= '0;
            ahal_reg  <= '0;
            ninv_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            ah_reg    <= ah;
            ahal_reg  <= ah ^ al;
            ninv_reg  <= norm_inv;
            valid_reg <= 1'b1;
        end
    end

    assign ah_s   = ah_reg;
    assign ahal_s = ahal_reg;
    assign ninv_s = ninv_reg;
`else
    assign ah_s   = ah;
    assign ahal_s = ah ^ al;
    assign ninv_s = norm_inv;
`endif

    // Inverse = (ah*X + (ah^al)) / norm.
    assign inv_byte = {gf16_mul(ah_s, ninv_s), gf16_mul(ahal_s, ninv_s)};

    // Back to the AES basis merged with the affine transform.
    assign sbox_comb = mat_mul(INV_AFFINE_MAP, inv_byte) ^ SBOX_AFFINE_C;

`ifdef SBOX_PIPE_EN
    assign sstate_next = valid_reg ? sbox_comb : 8'h00;
`else
    assign sstate_next = sbox_comb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sstate_reg <= 8'h00;
        else     sstate_reg <= sstate_next;
    end

    assign Sstate = sstate_reg;

endmodule

// File: tb/tb_sub_bytes.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes
// Self-checking bench for sub_bytes: directed table, exhaustive sweep,
// random stream, hold and asynchronous reset sequences. Expected values come
// from a plain GF(2^8) arithmetic model of the S-box.
// -----------------------------------------------------------------------------
module tb_sub_bytes;

`ifdef SBOX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] state = 8'h00;
    logic [7:0] Sstate;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] hist[$];
    vec_t       vecs[6];

    sub_bytes dut (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .Sstate (Sstate)
    );

    always #5 clk = ~clk;

    // ---- reference model ----------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (a != 8'h00)
            for (int c = 1; c < 256; c++)
                if (gmul(a, 8'(c)) == 8'h01) r = 8'(c);
        return r;
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] a);
        logic [7:0] b, c, s;
        b = ginv(a);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                 ^ b[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    // ---- checking helpers ---------------------------------------------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: Sstate=%02h required=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply v for one edge; e is S(v). Output is compared to the value
    // queued LAT edges ago, or 0 while the pipe is still refilling after reset.
    task automatic drive(input logic [7:0] v, input logic [7:0] e, input string name);
        logic [7:0] expv;
        state = v;
        @(posedge clk);
        #1;
        hist.push_back(e);
        if (hist.size() >= LAT) expv = hist[hist.size() - LAT];
        else                    expv = 8'h00;
        $display("[%0t] %s in=%02h out=%02h exp=%02h", $time, name, v, Sstate, expv);
        check(name, Sstate, expv);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    // 3 ns reset pulse between edges (called 1 ns after an edge).
    task automatic pulse_rst(input string name);
        #1 rst = 1'b1;
        #1 check(name, Sstate, 8'h00);
        #2 rst = 1'b0;
        #1 check({name, "_release"}, Sstate, 8'h00);
        hist.delete();
    endtask

    initial begin
        vecs[0] = '{din: 8'h00, dout: 8'h63};
        vecs[1] = '{din: 8'h01, dout: 8'h7c};
        vecs[2] = '{din: 8'h02, dout: 8'h77};
        vecs[3] = '{din: 8'hff, dout: 8'h16};
        vecs[4] = '{din: 8'h4f, dout: 8'h84};
        vecs[5] = '{din: 8'h53, dout: 8'hed};

        // Asynchronous reset before any clock edge, held across two edges.
        state = 8'h01;
        #2 rst = 1'b1;
        #1 check("reset_async", Sstate, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1 check("reset_hold", Sstate, 8'h00);
        end
        #2 rst = 1'b0;
        hist.delete();
        drive(8'h01, 8'h7c, "post_reset");
        drive(8'h01, 8'h7c, "post_reset");

        // Directed vectors, back-to-back.
        for (int i = 0; i < 6; i++)
            drive(vecs[i].din, vecs[i].dout, "directed");

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++)
            drive(8'(i), sbox_model(8'(i)), "sweep");

        // Random stream.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(255));
            drive(r, sbox_model(r), "random");
        end

        // Hold input constant.
        for (int i = 0; i < 5; i++)
            drive(8'h4f, 8'h84, "hold");

        // Reset in the middle of a stream; in-flight data is dropped.
        drive(8'h00, 8'h63, "stream");
        drive(8'h01, 8'h7c, "stream");
        drive(8'h02, 8'h77, "stream");
        pulse_rst("reset_mid");
        drive(8'h02, 8'h77, "after_mid_reset");
        drive(8'h53, 8'hed, "after_mid_reset");
        drive(8'hff, 8'h16, "after_mid_reset");

        // Directed vectors again straight after a reset.
        pulse_rst("reset_pre_dir");
        for (int i = 0; i < 6; i++)
            drive(vecs[i].din, vecs[i].dout, "directed2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
